// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle control path: FSM state encoding,
// opcode/funct constants, ALU select codes and mux encodings.
// Optional build macro: ILLEGAL_TRAP_EN (adds the HALT state).
package cpu_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEM_ADDR,
      S_MEM_READ,
      S_MEM_WB,
      S_MEM_WRITE,
      S_EXECUTE,
      S_ALU_WB,
      S_IMM_EXEC,
      S_IMM_WB,
      S_BRANCH,
      S_JUMP
`ifdef ILLEGAL_TRAP_EN
      , S_HALT
`endif
   } state_e;

   // Opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes (instr[5:0])
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALU operation select
   localparam logic [2:0] ALU_ZERO  = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_XOR   = 3'b100;
   localparam logic [2:0] ALU_SLTU  = 3'b101;
   localparam logic [2:0] ALU_SRL1  = 3'b110;
   localparam logic [2:0] ALU_PASSA = 3'b111;

   // ALU operand B mux
   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // Next-PC mux
   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decoder: maps funct to an ALU select code and flags
// funct values the core does not implement (those select ALU_ZERO).
module alu_decoder
   import cpu_pkg::*;
#(
   parameter int FUNCT_W = 6,
   parameter int SEL_W   = 3
) (
   input  logic [FUNCT_W-1:0] funct,
   output logic [SEL_W-1:0]   alu_select,
   output logic               illegal
);

   // Pure lookup; unknown funct produces a zero result and raises illegal.
   always_comb begin
      alu_select = ALU_ZERO;
      illegal    = 1'b0;
      case (funct)
         FN_ADD:  alu_select = ALU_ADD;
         FN_AND:  alu_select = ALU_AND;
         FN_OR:   alu_select = ALU_OR;
         FN_XOR:  alu_select = ALU_XOR;
         FN_SLT:  alu_select = ALU_SLTU;
         FN_SRL:  alu_select = ALU_SRL1;
         default: illegal    = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle core: fetch/decode/execute/memory/
// writeback sequencing, ALU select and operand muxes, PC-enable decision.
// Optional build macro: ILLEGAL_TRAP_EN -- illegal instructions park the FSM
// in HALT (all controls low, `halted` high) until reset.
module multicycle_control
   import cpu_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int FUNCT_W  = 6,
   parameter int SEL_W    = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                ir_write,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [SEL_W-1:0]    alu_select,
   output logic [1:0]          pc_src,
   output logic                pc_en,
`ifdef ILLEGAL_TRAP_EN
   output logic                halted,
`endif
   output logic                illegal_op
);

   state_e             state_q, state_d;
   logic               illegal_q, illegal_d;
   logic [SEL_W-1:0]   fn_select;
   logic               fn_illegal;

   alu_decoder #(
      .FUNCT_W (FUNCT_W),
      .SEL_W   (SEL_W)
   ) u_alu_decoder (
      .funct      (funct),
      .alu_select (fn_select),
      .illegal    (fn_illegal)
   );

   // State register and sticky illegal flag; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state and control outputs; everything is low unless a state drives it,
   // and everything is forced low while reset is held.
   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      alu_select = ALU_ZERO;
      pc_src     = PC_ALU;
      pc_en      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      halted     = 1'b0;
`endif

      case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            // PC+4 and IR load happen only on the cycle memory delivers
            if (mem_ready) begin
               ir_write   = 1'b1;
               alu_src_b  = SRCB_FOUR;
               alu_select = ALU_ADD;
               pc_en      = 1'b1;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            // Speculatively compute the branch target into ALUOut
            alu_src_b  = SRCB_IMM_SH2;
            alu_select = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW:              state_d = S_MEM_ADDR;
               OP_RTYPE:                  state_d = S_EXECUTE;
               OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMM_EXEC;
               OP_BEQ:                    state_d = S_BRANCH;
               OP_J:                      state_d = S_JUMP;
               default: begin
                  illegal_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                  state_d   = S_HALT;
`else
                  state_d   = S_FETCH;
`endif
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            alu_select = ALU_ADD;
            state_d    = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECUTE: begin
            alu_src_a  = 1'b1;
            alu_select = fn_select;
            state_d    = S_ALU_WB;
            if (fn_illegal) begin
               illegal_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
               state_d   = S_HALT;
`endif
            end
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_IMM_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            case (opcode)
               OP_ANDI: alu_select = ALU_AND;
               OP_ORI:  alu_select = ALU_OR;
               default: alu_select = ALU_ADD;
            endcase
            state_d = S_IMM_WB;
         end
         S_IMM_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            // xor of equal operands is zero, so zero means "taken"
            alu_src_a  = 1'b1;
            alu_select = ALU_XOR;
            pc_src     = PC_ALUOUT;
            pc_en      = zero;
            state_d    = S_FETCH;
         end
         S_JUMP: begin
            pc_src  = PC_JUMP;
            pc_en   = 1'b1;
            state_d = S_FETCH;
         end
`ifdef ILLEGAL_TRAP_EN
         S_HALT: begin
            halted  = 1'b1;
            state_d = S_HALT;
         end
`endif
         default: state_d = S_FETCH;
      endcase

      if (rst) begin
         ir_write   = 1'b0;
         i_or_d     = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         mem_to_reg = 1'b0;
         reg_dst    = 1'b0;
         reg_write  = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = SRCB_REG;
         alu_select = ALU_ZERO;
         pc_src     = PC_ALU;
         pc_en      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
         halted     = 1'b0;
`endif
      end
   end

   assign illegal_op = illegal_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM of the multicycle core. Sits directly upstream of the ALU and drives its 3-bit operation select and its operand muxes.
- Sequences fetch, decode, execute, memory and writeback for a MIPS-style subset.
- Owns the PC-enable decision, which combines its own control with the ALU `zero` flag fed back from the ALU.

Parameters:
- OPCODE_W, 6, instruction opcode field width
- FUNCT_W, 6, R-type funct field width
- SEL_W, 3, ALU select width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  OPCODE_W  instr[31:26], sampled from the instruction register
- funct  in  FUNCT_W  instr[5:0]
- zero  in  1  ALU zero flag, combinational from the ALU
- mem_ready  in  1  memory completes the current access this cycle
- ir_write  out  1  load the instruction register
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU operand A: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU operand B: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_select  out  SEL_W  ALU operation code
- pc_src  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC register load enable
- illegal_op  out  1  sticky flag: unsupported opcode or funct decoded

Behaviour:
- ALU select codes:
  - 001 add
  - 010 and
  - 011 or
  - 100 xor
  - 101 set-less-than (unsigned)
  - 110 shift right by 1
  - 111 pass A
  - 000 yields zero result
- Supported instructions:
  - R-type (opcode 0x00), by funct: add 0x20 -> 001, and 0x24 -> 010, or 0x25 -> 011, xor 0x26 -> 100, slt 0x2A -> 101, srl 0x02 -> 110.
  - I-type, by opcode: addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- States and transitions:
  - FETCH: mem_read=1, i_or_d=0. Hold until mem_ready. On the mem_ready cycle also assert ir_write=1, alu_src_a=0, alu_src_b=01, alu_select=001, pc_src=00, pc_en=1; next state is DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_select=001 (branch target into ALUOut). Dispatches on opcode:
    - lw/sw -> MEM_ADDR
    - R-type -> EXECUTE
    - addi/andi/ori -> IMM_EXEC
    - beq -> BRANCH
    - j -> JUMP
    - anything else -> FETCH with illegal_op set
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_select=001. lw -> MEM_READ; sw -> MEM_WRITE.
  - MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
  - MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_select from funct. Unknown funct gives alu_select=000 and sets illegal_op. Next state ALU_WB.
  - ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH. An unknown funct still writes back 0.
  - IMM_EXEC: alu_src_a=1, alu_src_b=10. alu_select is 001 (addi), 010 (andi) or 011 (ori). Next state IMM_WB.
  - IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_select=100 (xor), pc_src=01, pc_en=zero. Next state FETCH.
  - JUMP: pc_src=10, pc_en=1. Next state FETCH.
- Output timing:
  - All outputs are combinational from state, opcode, funct, zero and mem_ready (Mealy only where stated).
  - Every output not listed for a state is 0.
- Reset: asynchronous. State becomes FETCH and illegal_op clears to 0. While rst is high, every output is 0, including mem_read.
- Latencies with zero-wait memory:
  - lw: 5 cycles
  - R-type, addi/andi/ori, sw: 4 cycles
  - beq, j: 3 cycles
- Memory wait: mem_ready low holds the current state indefinitely with outputs stable. pc_en and ir_write assert only on the mem_ready cycle.
- Reset mid-access aborts the access. No write completes after reset rises.
- illegal_op: set in the cycle after the offending decode, held until reset.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN
- Defined: an unsupported opcode or funct enters state HALT instead of continuing. HALT drives all outputs 0 and stays there until rst. An extra output `halted`=1 in HALT.
- Undefined: no HALT state and no `halted` port. Illegal instructions behave as NOP-like per the Behaviour rules; illegal_op still flags them.

Decomposition:
- Shared package `cpu_pkg`:
  - state enum
  - opcode and funct constants
  - ALU select codes (ALU_ADD=3'b001 ... ALU_PASSA=3'b111)
  - alu_src_b and pc_src encodings
- One sub-module, `alu_decoder`: combinational funct -> {alu_select, illegal}. Instantiated inside EXECUTE decoding.

Test Plan:
- Reset mid-FETCH with mem_read=1 -> outputs all 0 immediately; after release, state FETCH and illegal_op=0.
- add (funct 0x20), mem_ready always 1 -> 4 cycles; EXECUTE drives alu_select=001; ALU_WB drives reg_write=1, reg_dst=1.
- lw with mem_ready low for 3 cycles in MEM_READ -> state held, mem_read=1, i_or_d=1 throughout; MEM_WB follows one cycle after mem_ready; total 8 cycles.
- beq with zero=1 -> BRANCH asserts pc_en=1, pc_src=01, alu_select=100; repeat with zero=0 -> pc_en=0.
- ori (0x0D) -> IMM_EXEC alu_select=011, alu_src_b=10; IMM_WB reg_write=1, reg_dst=0.
- opcode 0x3F -> illegal_op=1 from the next cycle. With ILLEGAL_TRAP_EN: halted=1, all outputs 0 until rst. Without it: back in FETCH, mem_read=1.
